// File: rtl/bids_nway_pkg.sv
// Shared types and codes for the N-way sealed-bid auction controller.
package bids_nway_pkg;

    localparam int CTL_W = 32;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_UNLOCK    = 4'd1,
        OP_LOCK      = 4'd2,
        OP_SETIDX    = 4'd3,
        OP_LOADBAL   = 4'd4,
        OP_SETMASK   = 4'd5,
        OP_SETTIMER  = 4'd6,
        OP_BIDCHARGE = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ROUND    = 2'd2,
        ST_RESULT   = 2'd3
    } state_e;

    // Per-bidder error codes
    localparam logic [1:0] BERR_NONE     = 2'd0;
    localparam logic [1:0] BERR_INACTIVE = 2'd1;
    localparam logic [1:0] BERR_FUNDS    = 2'd2;
    localparam logic [1:0] BERR_MASKED   = 2'd3;

    // Controller error codes
    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_BAD_KEY  = 3'd1;
    localparam logic [2:0] ERR_UNLOCKED = 3'd2;
    localparam logic [2:0] ERR_START    = 3'd3;
    localparam logic [2:0] ERR_INVALID  = 3'd4;
    localparam logic [2:0] ERR_TIE      = 3'd5;

endpackage

// File: rtl/bids_max_sel.sv
// Combinational winner selection: unique nonzero maximum wins, equal maxima tie.
module bids_max_sel
    import bids_nway_pkg::*;
#(
    parameter int NUM_BIDDERS = 3,
    parameter int AMT_W       = 16
) (
    input  logic [NUM_BIDDERS*AMT_W-1:0] cur,
    output logic [AMT_W-1:0]             max_val,
    output logic [NUM_BIDDERS-1:0]       win,
    output logic                         tie
);

    logic [NUM_BIDDERS-1:0] hit;
    logic [5:0]             hit_cnt;

    // Largest standing bid across all bidders
    always_comb begin
        max_val = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (cur[i*AMT_W +: AMT_W] > max_val) begin
                max_val = cur[i*AMT_W +: AMT_W];
            end
        end
    end

    // Flag every bidder sitting at a nonzero maximum and count them
    always_comb begin
        hit     = '0;
        hit_cnt = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            hit[i]  = (max_val != '0) && (cur[i*AMT_W +: AMT_W] == max_val);
            hit_cnt = hit_cnt + 6'(hit[i]);
        end
    end

    assign tie = (hit_cnt > 6'd1);
    assign win = (hit_cnt == 6'd1) ? hit : '0;

endmodule

// File: rtl/bids_nway.sv
// N-way sealed-bid auction controller: control-port FSM plus per-bidder bid datapath.
module bids_nway
    import bids_nway_pkg::*;
#(
    parameter int NUM_BIDDERS = 3,
    parameter int AMT_W       = 16,
    parameter int BAL_W       = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_BIDDERS-1:0]       bid,
    input  logic [NUM_BIDDERS*AMT_W-1:0] bid_amt,
    input  logic [NUM_BIDDERS-1:0]       retract,
    input  logic                         c_start,
    input  logic [3:0]                   c_op,
    input  logic [CTL_W-1:0]             c_data,
    output logic [NUM_BIDDERS-1:0]       ack,
    output logic [NUM_BIDDERS*2-1:0]     berr,
    output logic [NUM_BIDDERS-1:0]       win,
    output logic [NUM_BIDDERS*BAL_W-1:0] balance,
    output logic                         ready,
    output logic                         round_over,
    output logic [2:0]                   err,
    output logic [AMT_W-1:0]             max_bid
);

    localparam int IDX_W = $clog2(NUM_BIDDERS);
    // Funds check width: wide enough that amount + cost can never wrap
    localparam int SUM_W = ((BAL_W > CTL_W) ? BAL_W : CTL_W) + 1;

    state_e                   state;
    op_e                      op;
    logic [CTL_W-1:0]         key;
    logic [CTL_W-1:0]         timer_cfg;
    logic [CTL_W-1:0]         bid_cost;
    logic [CTL_W-1:0]         tcnt;
    logic [IDX_W-1:0]         idx;
    logic [NUM_BIDDERS-1:0]   mask;
    logic                     start_q;
    logic [AMT_W-1:0]         cur [NUM_BIDDERS];
    logic [BAL_W-1:0]         bal [NUM_BIDDERS];
    logic [NUM_BIDDERS*AMT_W-1:0] cur_flat;
    logic [AMT_W-1:0]         sel_max;
    logic [NUM_BIDDERS-1:0]   sel_win;
    logic                     sel_tie;

    logic start_rise;
    logic round_end;
    logic round_enter;
    logic load_bal;
    logic idx_bad;

    function automatic logic funds_short(input logic [BAL_W-1:0] b,
                                         input logic [AMT_W-1:0] a,
                                         input logic [CTL_W-1:0] c);
        logic [SUM_W-1:0] need;
        need = SUM_W'(a) + SUM_W'(c);
        return (SUM_W'(b) < need);
    endfunction

    assign op          = op_e'(c_op);
    assign start_rise  = c_start & ~start_q;
    assign round_end   = !c_start || ((timer_cfg != '0) && (tcnt == CTL_W'(1)));
    assign round_enter = (state == ST_LOCKED) && start_rise;
    assign load_bal    = (state == ST_UNLOCKED) && (op == OP_LOADBAL);
    assign idx_bad     = (32'(c_data[IDX_W-1:0]) >= 32'(NUM_BIDDERS));

    for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_flat
        assign cur_flat[g*AMT_W +: AMT_W] = cur[g];
        assign balance[g*BAL_W +: BAL_W]  = bal[g];
    end

    bids_max_sel #(
        .NUM_BIDDERS (NUM_BIDDERS),
        .AMT_W       (AMT_W)
    ) u_max_sel (
        .cur     (cur_flat),
        .max_val (sel_max),
        .win     (sel_win),
        .tie     (sel_tie)
    );

    // Control FSM: lock/unlock, configuration registers, round timing and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_UNLOCKED;
            key        <= '0;
            idx        <= '0;
            mask       <= '1;
            timer_cfg  <= CTL_W'(32'hF);
            bid_cost   <= CTL_W'(1);
            tcnt       <= '0;
            start_q    <= 1'b0;
            err        <= ERR_OK;
            ready      <= 1'b0;
            round_over <= 1'b0;
            win        <= '0;
            max_bid    <= '0;
        end else begin
            start_q    <= c_start;
            round_over <= 1'b0;
            case (state)
                ST_UNLOCKED: begin
                    ready <= 1'b1;
                    case (op)
                        OP_NOP:       ;
                        OP_UNLOCK:    err <= ERR_UNLOCKED;
                        OP_LOCK: begin
                            key   <= c_data;
                            state <= ST_LOCKED;
                            err   <= ERR_OK;
                        end
                        OP_SETIDX: begin
                            if (idx_bad) begin
                                err <= ERR_INVALID;
                            end else begin
                                idx <= c_data[IDX_W-1:0];
                                err <= ERR_OK;
                            end
                        end
                        OP_LOADBAL:   err <= ERR_OK;
                        OP_SETMASK: begin
                            mask <= c_data[NUM_BIDDERS-1:0];
                            err  <= ERR_OK;
                        end
                        OP_SETTIMER: begin
                            timer_cfg <= c_data;
                            err       <= ERR_OK;
                        end
                        OP_BIDCHARGE: begin
                            bid_cost <= c_data;
                            err      <= ERR_OK;
                        end
                        default:      err <= ERR_INVALID;
                    endcase
                    // A start request while unlocked outranks any op error
                    if (c_start) begin
                        err <= ERR_START;
                    end
                end
                ST_LOCKED: begin
                    ready <= !start_rise;
                    case (op)
                        OP_NOP: ;
                        OP_UNLOCK: begin
                            if (c_data == key) begin
                                state <= ST_UNLOCKED;
                                err   <= ERR_OK;
                            end else begin
                                err <= ERR_BAD_KEY;
                            end
                        end
                        default: err <= ERR_INVALID;
                    endcase
                    if (start_rise) begin
                        state   <= ST_ROUND;
                        tcnt    <= timer_cfg;
                        win     <= '0;
                        max_bid <= '0;
                    end
                end
                ST_ROUND: begin
                    ready <= 1'b0;
                    tcnt  <= tcnt - CTL_W'(1);
                    if (round_end) begin
                        state <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    ready      <= 1'b1;
                    win        <= sel_win;
                    max_bid    <= sel_max;
                    round_over <= 1'b1;
                    state      <= ST_LOCKED;
                    if (sel_tie) begin
                        err <= ERR_TIE;
                    end
                end
                default: state <= ST_UNLOCKED;
            endcase
        end
    end

    // Bid datapath: per-bidder accept/reject, standing bids, balance charges and debits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack  <= '0;
            berr <= '0;
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                cur[i] <= '0;
                bal[i] <= '0;
            end
        end else begin
            ack  <= '0;
            berr <= '0;
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (state == ST_ROUND) begin
                    if (retract[i]) begin
                        cur[i] <= '0;
                        ack[i] <= 1'b1;
                    end else if (bid[i]) begin
                        if (!mask[i]) begin
                            berr[i*2 +: 2] <= BERR_MASKED;
                        end else if (funds_short(bal[i], bid_amt[i*AMT_W +: AMT_W], bid_cost)) begin
                            berr[i*2 +: 2] <= BERR_FUNDS;
                        end else begin
                            cur[i] <= bid_amt[i*AMT_W +: AMT_W];
                            bal[i] <= bal[i] - BAL_W'(bid_cost);
                            ack[i] <= 1'b1;
                        end
                    end
                end else begin
                    if (bid[i] || retract[i]) begin
                        berr[i*2 +: 2] <= BERR_INACTIVE;
                    end
                    if (round_enter) begin
                        cur[i] <= '0;
                    end
                    if (load_bal && (idx == IDX_W'(i))) begin
                        bal[i] <= BAL_W'(c_data);
                    end
                    if ((state == ST_RESULT) && sel_win[i]) begin
                        bal[i] <= bal[i] - BAL_W'(cur[i]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bids_nway.sv
// Randomised scoreboard bench for bids_nway against a behavioural auction model.
module tb_bids_nway;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int BW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    bid;
    logic [N*AW-1:0] bid_amt;
    logic [N-1:0]    retract;
    logic            c_start;
    logic [3:0]      c_op;
    logic [31:0]     c_data;
    logic [N-1:0]    ack;
    logic [2*N-1:0]  berr;
    logic [N-1:0]    win;
    logic [N*BW-1:0] balance;
    logic            ready;
    logic            round_over;
    logic [2:0]      err;
    logic [AW-1:0]   max_bid;

    always #5 clk = ~clk;

    bids_nway #(.NUM_BIDDERS(N), .AMT_W(AW), .BAL_W(BW)) dut (
        .clk(clk), .reset_n(reset_n), .bid(bid), .bid_amt(bid_amt), .retract(retract),
        .c_start(c_start), .c_op(c_op), .c_data(c_data), .ack(ack), .berr(berr),
        .win(win), .balance(balance), .ready(ready), .round_over(round_over),
        .err(err), .max_bid(max_bid)
    );

    typedef struct packed {
        logic [N-1:0]   ack;
        logic [2*N-1:0] berr;
    } resp_t;

    typedef struct packed {
        logic [N-1:0]  win;
        logic [AW-1:0] mx;
        logic [2:0]    err;
    } res_t;

    resp_t rq[$];
    res_t  resq[$];
    resp_t mon_r;
    res_t  mon_s;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    longint      m_bal [N];
    int          m_cur [N];
    logic [N-1:0] m_mask;
    longint      m_cost;
    logic [31:0] m_key;
    int          m_idx;
    logic [2:0]  m_err;
    bit          m_locked;
    bit          m_inround;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bal[i] = 0;
            m_cur[i] = 0;
        end
        m_mask = '1; m_cost = 1; m_key = 0; m_idx = 0; m_err = 0;
        m_locked = 0; m_inround = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*AW-1:0] amts3(input int x, input int y, input int z);
        return {AW'(z), AW'(y), AW'(x)};
    endfunction

    task automatic chk_bal();
        for (int i = 0; i < N; i++) check("balance", balance[i*BW +: BW], m_bal[i]);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_berr"}, berr, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_round_over"}, round_over, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_max_bid"}, max_bid, 0);
        for (int i = 0; i < N; i++) check({tag, "_balance"}, balance[i*BW +: BW], 0);
    endtask

    // Control operation: model the expected controller error, apply, then compare
    task automatic ctl(input logic [3:0] op, input logic [31:0] d);
        logic [2:0] e;
        e = m_err;
        if (!m_locked) begin
            case (op)
                4'd0: ;
                4'd1: e = 2;
                4'd2: begin m_key = d; m_locked = 1; e = 0; end
                4'd3: if (d[1:0] >= N) e = 4; else begin m_idx = int'(d[1:0]); e = 0; end
                4'd4: begin m_bal[m_idx] = longint'(d); e = 0; end
                4'd5: begin m_mask = d[N-1:0]; e = 0; end
                4'd6: e = 0;
                4'd7: begin m_cost = longint'(d); e = 0; end
                default: e = 4;
            endcase
        end else if (op == 4'd1) begin
            if (d == m_key) begin m_locked = 0; e = 0; end
            else e = 1;
        end else if (op != 4'd0) begin
            e = 4;
        end
        m_err = e;
        c_op = op; c_data = d;
        step();
        c_op = 0; c_data = 0;
        check("ctl_err", err, m_err);
        check("ctl_ready", ready, 1);
    endtask

    // One cycle of bidder requests; expected pulses go to the scoreboard
    task automatic drive(input logic [N-1:0] b, input logic [N-1:0] r, input logic [N*AW-1:0] a);
        resp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            int amt;
            amt = int'(a[i*AW +: AW]);
            if (!m_inround) begin
                if (b[i] || r[i]) e.berr[2*i +: 2] = 2'd1;
            end else if (r[i]) begin
                m_cur[i] = 0;
                e.ack[i] = 1'b1;
            end else if (b[i]) begin
                if (!m_mask[i]) e.berr[2*i +: 2] = 2'd3;
                else if (m_bal[i] < longint'(amt) + m_cost) e.berr[2*i +: 2] = 2'd2;
                else begin
                    m_cur[i] = amt;
                    m_bal[i] -= m_cost;
                    e.ack[i] = 1'b1;
                end
            end
        end
        if (e != '0) rq.push_back(e);
        bid = b; retract = r; bid_amt = a;
        step();
        bid = 0; retract = 0; bid_amt = 0;
    endtask

    // Expected round outcome from the standing bids
    task automatic push_result();
        res_t s;
        int mx, cnt, w;
        mx = 0; cnt = 0; w = 0;
        for (int i = 0; i < N; i++) if (m_cur[i] > mx) mx = m_cur[i];
        for (int i = 0; i < N; i++) if (mx != 0 && m_cur[i] == mx) begin cnt++; w = i; end
        s = '0;
        s.mx = AW'(mx);
        if (cnt == 1) begin
            s.win[w] = 1'b1;
            m_bal[w] -= longint'(mx);
        end else if (cnt > 1) begin
            m_err = 5;
        end
        s.err = m_err;
        resq.push_back(s);
    endtask

    task automatic start_round();
        c_start = 1;
        step();
        for (int i = 0; i < N; i++) m_cur[i] = 0;
        m_inround = 1;
    endtask

    task automatic end_round(input logic [N-1:0] b, input logic [N-1:0] r, input logic [N*AW-1:0] a);
        c_start = 0;
        drive(b, r, a);
        m_inround = 0;
        push_result();
        step();
        chk_bal();
        check("ready_after_round", ready, 1);
    endtask

    // Scoreboard monitor: pop an expectation whenever the DUT presents a response
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (|{ack, berr} !== 1'b0) begin
                if (rq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL resp_unexpected: ack=%b berr=%b, expected no response", ack, berr);
                end else begin
                    mon_r = rq.pop_front();
                    check("ack", ack, mon_r.ack);
                    check("berr", berr, mon_r.berr);
                end
            end
            if (round_over !== 1'b0) begin
                if (resq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL round_over_unexpected: round_over=%b, expected 0", round_over);
                end else begin
                    mon_s = resq.pop_front();
                    check("win", win, mon_s.win);
                    check("max_bid", max_bid, mon_s.mx);
                    check("result_err", err, mon_s.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] key;
        reset_n = 0; bid = 0; bid_amt = 0; retract = 0; c_start = 0; c_op = 0; c_data = 0;
        model_reset();
        #12;
        chk_zero("reset");
        #10 reset_n = 1;
        step();
        check("ready_after_reset", ready, 1);

        // Configuration, then a clean round
        key = 32'h0F0F0F0F;
        ctl(3, 0); ctl(4, 100);
        ctl(3, 1); ctl(4, 50);
        ctl(3, 2); ctl(4, 80);
        ctl(3, 3);
        ctl(2, key);
        start_round();
        drive(3'b111, 3'b000, amts3(40, 30, 20));
        end_round(0, 0, 0);
        check("r1_win", win, 3'b001);
        check("r1_max", max_bid, 40);
        check("r1_bal_x", balance[0 +: BW], 59);
        check("r1_bal_y", balance[BW +: BW], 49);
        check("r1_bal_z", balance[2*BW +: BW], 79);

        // Tie at the maximum
        start_round();
        drive(3'b111, 3'b000, amts3(30, 30, 10));
        end_round(0, 0, 0);
        check("tie_err", err, 5);
        check("tie_win", win, 0);
        check("tie_max", max_bid, 30);

        // Masked bidder
        ctl(1, key); ctl(5, 32'h5); ctl(2, key);
        start_round();
        drive(3'b010, 3'b000, amts3(0, 10, 0));
        end_round(0, 0, 0);

        // Insufficient funds
        ctl(1, key); ctl(5, 32'h7); ctl(3, 1); ctl(4, 5); ctl(2, key);
        start_round();
        drive(3'b010, 3'b000, amts3(0, 5, 0));
        end_round(0, 0, 0);
        check("funds_bal_y", balance[BW +: BW], 5);

        // Timeout with c_start held high
        ctl(1, key); ctl(6, 4); ctl(2, key);
        c_start = 1;
        step();
        for (int i = 0; i < N; i++) m_cur[i] = 0;
        push_result();
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (round_over === 1'b1) begin k = i; break; end
        end
        check("timeout_cycles", k, 5);
        repeat (6) step();
        check("no_restart_ready", ready, 1);
        c_start = 0;
        step();
        start_round();
        end_round(0, 0, 0);

        // Key and state errors
        ctl(1, 32'h1234);
        ctl(9, 0);
        ctl(1, key);
        ctl(1, 0);
        ctl(9, 0);
        c_start = 1;
        step();
        m_err = 3;
        check("start_unlocked_err", err, 3);
        c_start = 0;
        step();
        drive(3'b001, 3'b000, amts3(5, 0, 0));

        // Retract, timer disabled
        ctl(6, 0); ctl(3, 0); ctl(4, 100); ctl(3, 1); ctl(4, 50); ctl(2, key);
        start_round();
        drive(3'b001, 3'b000, amts3(60, 0, 0));
        drive(3'b000, 3'b001, 0);
        drive(3'b010, 3'b000, amts3(0, 10, 0));
        repeat (4) drive(0, 0, 0);
        end_round(0, 0, 0);
        check("retract_win", win, 3'b010);
        check("retract_max", max_bid, 10);

        // Randomised rounds
        for (int r = 0; r < 20; r++) begin
            ctl(1, m_key);
            for (int i = 0; i < N; i++) begin
                ctl(3, 32'(i));
                ctl(4, $urandom_range(10, 150));
            end
            ctl(5, $urandom_range(1, 7));
            ctl(7, $urandom_range(0, 3));
            ctl(2, $urandom);
            start_round();
            k = $urandom_range(1, 8);
            for (int c = 0; c < k; c++) begin
                drive(3'($urandom), 3'($urandom & $urandom & $urandom),
                      amts3($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40)));
            end
            end_round(3'($urandom), 3'($urandom & $urandom),
                      amts3($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40)));
        end

        // Reset in the middle of a round
        ctl(1, m_key); ctl(3, 1); ctl(4, 50); ctl(5, 32'h2); ctl(2, key);
        start_round();
        drive(3'b010, 3'b000, amts3(0, 10, 0));
        step();
        reset_n = 0;
        #2;
        chk_zero("midreset");
        c_start = 0;
        model_reset();
        #3 reset_n = 1;
        step();
        check("ready_after_midreset", ready, 1);
        ctl(1, 0);
        ctl(3, 1); ctl(4, 50); ctl(2, key);
        start_round();
        drive(3'b010, 3'b000, amts3(0, 10, 0));
        end_round(0, 0, 0);
        check("post_reset_win", win, 3'b010);
        check("post_reset_bal_y", balance[BW +: BW], 39);

        repeat (3) step();
        check("resp_queue_drained", rq.size(), 0);
        check("result_queue_drained", resq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
